token_lexer: RTL and testbench
==============================

TOKEN_LEXER -- requirements
Module: token_lexer

Interface
REQ-001 SHALL have parameter ID_MAX_CHARS, default 8, maximum identifier length stored.
REQ-002 SHALL have port clk, input, 1, sole clock; all logic on rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset, synchronous, active-low.
REQ-004 SHALL have port in_valid, input, 1, source character valid.
REQ-005 SHALL have port in_ready, output, 1, lexer consumes in_data this cycle when in_valid && in_ready.
REQ-006 SHALL have port in_data, input, 8, ASCII character; 0x00 (NUL) marks end of source.
REQ-007 SHALL have port tok_valid, output, 1, token available.
REQ-008 SHALL have port tok_ready, input, 1, downstream accepts the token.
REQ-009 SHALL have port tok_kind, output, 2, token kind: 0 reserved, 1 ident, 2 num, 3 eof.
REQ-010 SHALL have port tok_op, output, 5, reserved code; valid when tok_kind=0.
REQ-011 SHALL have port tok_num, output, 32, unsigned value; valid when tok_kind=2.
REQ-012 SHALL have port tok_text, output, 8*ID_MAX_CHARS, identifier text, first char in [7:0], unused bytes zero.
REQ-013 SHALL have port tok_len, output, 4, identifier length in characters.
REQ-014 SHALL have port err, output, 1, one-cycle pulse on a lexical error.

Function
REQ-015 Reserved codes SHALL be: + 0, - 1, * 2, / 3, ( 4, ) 5, < 6, <= 7, > 8, >= 9, = 10, == 11, != 12, ; 13, { 14, } 15, , 16, & 17, [ 18, ] 19, return 20, if 21, else 22, for 23, while 24, int 25, sizeof 26.
REQ-016 States SHALL be IDLE, IDENT, NUM, OP1, COMMENT, EMIT.
REQ-017 IDLE: space, tab, CR and LF consumed and discarded; a letter or '_' enters IDENT; a digit enters NUM; an operator character enters OP1 or EMIT; NUL emits an eof token.
REQ-018 IDENT: letters, digits and '_' consumed and appended; any other character ends the token and is NOT consumed.
REQ-019 A completed identifier matching a keyword exactly SHALL emit reserved with the keyword code; otherwise it emits ident.
REQ-020 NUM: value = value*10 + digit, modulo 2^32; a non-digit ends the token and is not consumed.
REQ-021 OP1 holds '<', '>', '=' or '!'. If the next char is '=', it is consumed and the two-char code is emitted; otherwise the single-char code is emitted and the char is not consumed. A lone '!' SHALL pulse err and emit nothing.
REQ-022 Token latency: tok_valid SHALL assert the cycle after the terminating character is presented, or after the last consumed character of a single-char token.
REQ-023 in_ready SHALL be 0 while in EMIT; token outputs SHALL stay stable while tok_valid && !tok_ready.
REQ-024 On the tok_valid && tok_ready handshake the lexer SHALL return to IDLE and clear text, length and value.
REQ-025 An identifier longer than ID_MAX_CHARS SHALL pulse err once, keep the first ID_MAX_CHARS chars, and consume the remaining chars.
REQ-026 An illegal character (e.g. '#') in IDLE SHALL be consumed, pulse err and produce no token.
REQ-027 NUL inside IDENT, NUM or OP1 SHALL terminate the pending token unconsumed; eof follows on the next IDLE pass.
REQ-028 After the eof handshake the lexer SHALL accept a new source stream.

Reset
REQ-029 On rst_n=0 at a clock edge: state IDLE, tok_valid 0, err 0, tok_kind 0, tok_op 0, tok_num 0, tok_text 0, tok_len 0.
REQ-030 in_ready SHALL be 0 during reset; any partial token SHALL be discarded without output.

Configuration
REQ-031 Macro LEXER_COMMENT_EN defined: '/' followed by '/' SHALL enter COMMENT, which consumes through LF inclusive with no token; a NUL in COMMENT emits eof; '/' followed by any other char emits code 3 without consuming that char.
REQ-032 Macro LEXER_COMMENT_EN undefined: '/' SHALL always emit code 3 immediately and COMMENT SHALL not exist.

Verification
REQ-033 "a<=10;" NUL, tok_ready=1 -> ident "a" len 1; reserved 7; num 10; reserved 13; eof.
REQ-034 "return x;" NUL -> reserved 20; ident "x"; reserved 13; eof; "returnx" -> ident "returnx" len 7.
REQ-035 tok_ready held 0 for 5 cycles on token "int" -> tok_kind 0 and tok_op 25 stable, in_ready 0 throughout; next token follows the handshake.
REQ-036 "//c\n1" NUL -> with macro: num 1, eof; without macro: reserved 3, reserved 3, ident "c", num 1, eof.
REQ-037 "4294967297" -> num 1; "abcdefghij" -> one err pulse, then ident "abcdefgh" len 8; "!x" -> err pulse, then ident "x".
REQ-038 rst_n low for 1 cycle mid-way through "abc" -> no token emitted; following "7;" NUL -> num 7, reserved 13, eof.

Source files
------------

// File: rtl/token_lexer.sv
// token_lexer: streaming C-subset lexer producing ident/num/reserved/eof tokens.
// Define LEXER_COMMENT_EN to enable // line comments.
module token_lexer #(
    parameter int ID_MAX_CHARS = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [7:0]                in_data,
    output logic                      tok_valid,
    input  logic                      tok_ready,
    output logic [1:0]                tok_kind,
    output logic [4:0]                tok_op,
    output logic [31:0]               tok_num,
    output logic [8*ID_MAX_CHARS-1:0] tok_text,
    output logic [3:0]                tok_len,
    output logic                      err
);
    localparam logic [3:0] MAXL = 4'(ID_MAX_CHARS);

    typedef enum logic [2:0] {
        IDLE, IDENT, NUM, OP1,
`ifdef LEXER_COMMENT_EN
        COMMENT,
`endif
        EMIT
    } state_t;

    state_t      state;
    logic [7:0]  op_ch;
    logic [47:0] kw;
    logic        ovf;
    logic [7:0]  c;
    logic        is_alpha, is_digit, is_id, is_ws, is_op1;
    logic [5:0]  kw_hit, sop;

    function automatic logic [5:0] kw_code(input logic [47:0] k, input logic [3:0] n);
        kw_code = (n == 4'd6 && k == 48'("return")) ? {1'b1, 5'd20} :
                  (n == 4'd2 && k == 48'("if"))     ? {1'b1, 5'd21} :
                  (n == 4'd4 && k == 48'("else"))   ? {1'b1, 5'd22} :
                  (n == 4'd3 && k == 48'("for"))    ? {1'b1, 5'd23} :
                  (n == 4'd5 && k == 48'("while"))  ? {1'b1, 5'd24} :
                  (n == 4'd3 && k == 48'("int"))    ? {1'b1, 5'd25} :
                  (n == 4'd6 && k == 48'("sizeof")) ? {1'b1, 5'd26} : 6'd0;
    endfunction

    function automatic logic [5:0] single_op(input logic [7:0] ch);
        case (ch)
            "+":     single_op = {1'b1, 5'd0};
            "-":     single_op = {1'b1, 5'd1};
            "*":     single_op = {1'b1, 5'd2};
`ifndef LEXER_COMMENT_EN
            "/":     single_op = {1'b1, 5'd3};
`endif
            "(":     single_op = {1'b1, 5'd4};
            ")":     single_op = {1'b1, 5'd5};
            ";":     single_op = {1'b1, 5'd13};
            "{":     single_op = {1'b1, 5'd14};
            "}":     single_op = {1'b1, 5'd15};
            ",":     single_op = {1'b1, 5'd16};
            "&":     single_op = {1'b1, 5'd17};
            "[":     single_op = {1'b1, 5'd18};
            "]":     single_op = {1'b1, 5'd19};
            default: single_op = 6'd0;
        endcase
    endfunction

    assign c        = in_data;
    assign is_alpha = (c >= "a" && c <= "z") || (c >= "A" && c <= "Z") || c == "_";
    assign is_digit = c >= "0" && c <= "9";
    assign is_id    = is_alpha || is_digit;
    assign is_ws    = c == 8'h20 || c == 8'h09 || c == 8'h0d || c == 8'h0a;
`ifdef LEXER_COMMENT_EN
    assign is_op1   = c == "<" || c == ">" || c == "=" || c == "!" || c == "/";
`else
    assign is_op1   = c == "<" || c == ">" || c == "=" || c == "!";
`endif
    assign kw_hit   = kw_code(kw, tok_len);
    assign sop      = single_op(c);

    // Terminating characters are left unconsumed, so in_ready reflects the current char.
    assign in_ready = rst_n & ((state == IDLE) | (state == IDENT & is_id) | (state == NUM & is_digit)
                    | (state == OP1 & (op_ch == "/" ? c == "/" : c == "="))
`ifdef LEXER_COMMENT_EN
                    | (state == COMMENT)
`endif
                    );

    task automatic emit(input logic [1:0] k, input logic [4:0] op);
        state     <= EMIT;
        tok_valid <= 1'b1;
        tok_kind  <= k;
        tok_op    <= op;
    endtask

    task automatic append();
        if (tok_len < MAXL) begin
            tok_text[8*tok_len +: 8] <= c;
            tok_len <= tok_len + 4'd1;
            kw      <= {kw[39:0], c};
        end else if (!ovf) begin
            err <= 1'b1;
            ovf <= 1'b1;
        end
    endtask

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            tok_valid <= 1'b0;
            err       <= 1'b0;
            tok_kind  <= '0;
            tok_op    <= '0;
            tok_num   <= '0;
            tok_text  <= '0;
            tok_len   <= '0;
            op_ch     <= '0;
            kw        <= '0;
            ovf       <= 1'b0;
        end else begin
            err <= 1'b0;
            case (state)
                IDLE: if (in_valid) begin
                    if (is_alpha) begin
                        state <= IDENT;
                        append();
                    end else if (is_digit) begin
                        state   <= NUM;
                        tok_num <= {28'd0, c[3:0]};
                    end else if (c == 8'h00) emit(2'd3, 5'd0);
                    else if (is_op1) begin
                        state <= OP1;
                        op_ch <= c;
                    end else if (sop[5]) emit(2'd0, sop[4:0]);
                    else if (!is_ws) err <= 1'b1;
                end
                IDENT: if (in_valid) begin
                    if (is_id) append();
                    else emit(kw_hit[5] ? 2'd0 : 2'd1, kw_hit[4:0]);
                end
                NUM: if (in_valid) begin
                    if (is_digit) tok_num <= tok_num * 32'd10 + {28'd0, c[3:0]};
                    else emit(2'd2, 5'd0);
                end
                OP1: if (in_valid) begin
`ifdef LEXER_COMMENT_EN
                    if (op_ch == "/") begin
                        if (c == "/") state <= COMMENT;
                        else emit(2'd0, 5'd3);
                    end else
`endif
                    if (c == "=") emit(2'd0, op_ch == "<" ? 5'd7 : op_ch == ">" ? 5'd9 : op_ch == "=" ? 5'd11 : 5'd12);
                    else if (op_ch == "!") begin
                        err   <= 1'b1;
                        state <= IDLE;
                    end else emit(2'd0, op_ch == "<" ? 5'd6 : op_ch == ">" ? 5'd8 : 5'd10);
                end
`ifdef LEXER_COMMENT_EN
                COMMENT: if (in_valid) begin
                    if (c == 8'h0a) state <= IDLE;
                    else if (c == 8'h00) emit(2'd3, 5'd0);
                end
`endif
                EMIT: if (tok_ready) begin
                    state     <= IDLE;
                    tok_valid <= 1'b0;
                    tok_text  <= '0;
                    tok_len   <= '0;
                    tok_num   <= '0;
                    kw        <= '0;
                    ovf       <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_token_lexer.sv
// tb_token_lexer: directed streams with hand-computed token lists for token_lexer.
module tb_token_lexer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_data = 8'h00;
    logic        tok_valid;
    logic        tok_ready = 1'b0;
    logic [1:0]  tok_kind;
    logic [4:0]  tok_op;
    logic [31:0] tok_num;
    logic [63:0] tok_text;
    logic [3:0]  tok_len;
    logic        err;

    token_lexer #(.ID_MAX_CHARS(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .tok_valid(tok_valid), .tok_ready(tok_ready), .tok_kind(tok_kind), .tok_op(tok_op),
        .tok_num(tok_num), .tok_text(tok_text), .tok_len(tok_len), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  k;
        logic [4:0]  op;
        logic [31:0] num;
        logic [63:0] text;
        logic [3:0]  len;
    } tok_t;

    tok_t exp_q[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [63:0] txt(input string s);
        logic [63:0] t = '0;
        for (int i = 0; i < s.len() && i < 8; i++) t[8*i +: 8] = s[i];
        return t;
    endfunction

    function automatic void add(input logic [1:0] k, input logic [4:0] op, input logic [31:0] num, input string s);
        tok_t t;
        t.k = k; t.op = op; t.num = num; t.text = txt(s); t.len = 4'(s.len() > 8 ? 8 : s.len());
        exp_q.push_back(t);
    endfunction

    // Feeds src followed by NUL; compares each handshaken token against exp_q.
    task automatic run(input string tag, input string src, input int exp_errs, input int stall);
        int pos = 0;
        int n = src.len() + 1;
        int errs = 0;
        int stall_left = stall;
        int cyc = 0;
        tok_t t;
        while ((pos < n || exp_q.size() > 0 || tok_valid) && cyc < 500) begin
            in_valid  = pos < n;
            in_data   = pos < src.len() ? src[pos] : 8'h00;
            tok_ready = stall_left == 0;
            @(negedge clk);
            if (err) errs++;
            if (tok_valid && stall_left > 0) begin
                chk({tag, " stall kind"}, tok_kind, exp_q[0].k);
                chk({tag, " stall op"}, tok_op, exp_q[0].op);
                chk({tag, " stall in_ready"}, in_ready, 0);
                stall_left--;
            end else if (tok_valid && tok_ready) begin
                if (exp_q.size() == 0) chk({tag, " extra token"}, 1, 0);
                else begin
                    t = exp_q.pop_front();
                    chk({tag, " kind"}, tok_kind, t.k);
                    if (t.k == 2'd0) chk({tag, " op"}, tok_op, t.op);
                    if (t.k == 2'd2) chk({tag, " num"}, tok_num, t.num);
                    if (t.k == 2'd1) begin
                        chk({tag, " text"}, tok_text, t.text);
                        chk({tag, " len"}, tok_len, t.len);
                    end
                end
            end
            if (in_valid && in_ready) pos++;
            @(posedge clk);
            #1;
            cyc++;
        end
        in_valid = 1'b0;
        chk({tag, " consumed"}, pos, n);
        chk({tag, " tokens left"}, exp_q.size(), 0);
        chk({tag, " err pulses"}, errs, exp_errs);
        exp_q.delete();
    endtask

    initial begin
        in_valid = 1'b1;
        in_data  = "a";
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("reset in_ready", in_ready, 0);
        chk("reset tok_valid", tok_valid, 0);
        chk("reset err", err, 0);
        chk("reset kind", tok_kind, 0);
        chk("reset op", tok_op, 0);
        chk("reset num", tok_num, 0);
        chk("reset text", tok_text, 0);
        chk("reset len", tok_len, 0);
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        in_valid = 1'b0;

        add(1, 0, 0, "a"); add(0, 7, 0, ""); add(2, 0, 10, ""); add(0, 13, 0, ""); add(3, 0, 0, "");
        run("a<=10", "a<=10;", 0, 0);

        add(0, 20, 0, ""); add(1, 0, 0, "x"); add(0, 13, 0, ""); add(3, 0, 0, "");
        run("return", "return x;", 0, 0);

        add(1, 0, 0, "returnx"); add(3, 0, 0, "");
        run("returnx", "returnx", 0, 0);

        add(0, 25, 0, ""); add(0, 13, 0, ""); add(3, 0, 0, "");
        run("stall", "int;", 0, 5);

`ifdef LEXER_COMMENT_EN
        add(2, 0, 1, ""); add(3, 0, 0, "");
`else
        add(0, 3, 0, ""); add(0, 3, 0, ""); add(1, 0, 0, "c"); add(2, 0, 1, ""); add(3, 0, 0, "");
`endif
        run("comment", "//c\n1", 0, 0);

        add(2, 0, 1, ""); add(3, 0, 0, "");
        run("wrap", "4294967297", 0, 0);

        add(1, 0, 0, "abcdefgh"); add(3, 0, 0, "");
        run("long ident", "abcdefghij", 1, 0);

        add(1, 0, 0, "x"); add(3, 0, 0, "");
        run("bang", "!x", 1, 0);

        add(3, 0, 0, "");
        run("illegal", "#", 1, 0);

        add(0, 11, 0, ""); add(0, 12, 0, ""); add(0, 8, 0, ""); add(0, 9, 0, ""); add(0, 0, 0, ""); add(3, 0, 0, "");
        run("ops", "==!=> >=+", 0, 0);

        in_valid = 1'b1;
        in_data  = "a";
        @(posedge clk);
        #1;
        in_data = "b";
        @(posedge clk);
        #1;
        rst_n   = 1'b0;
        in_data = "c";
        @(negedge clk);
        chk("midreset in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("midreset tok_valid", tok_valid, 0);
        chk("midreset len", tok_len, 0);
        chk("midreset text", tok_text, 0);
        @(posedge clk);
        #1;
        add(2, 0, 7, ""); add(0, 13, 0, ""); add(3, 0, 0, "");
        run("after reset", "7;", 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
